// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pkg
//  Purpose  : Shared definitions for the Hamming SECDED encoder/decoder pair:
//             codeword bit positions, fault-injection mode encodings, the
//             transmitter FSM state type and the injection-mask helper.
//  Ports    : (package, none)
//  Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Codeword layout {c_all,d3,d2,d1,c2,d0,c1,c0}, bit7 down to bit0
    localparam int C_BIT_C0   = 0;
    localparam int C_BIT_C1   = 1;
    localparam int C_BIT_D0   = 2;
    localparam int C_BIT_C2   = 3;
    localparam int C_BIT_D1   = 4;
    localparam int C_BIT_D2   = 5;
    localparam int C_BIT_D3   = 6;
    localparam int C_BIT_CALL = 7;

    // Fault-injection modes; 2'b11 is deliberately treated as "none"
    localparam logic [1:0] C_INJ_NONE   = 2'b00;
    localparam logic [1:0] C_INJ_SINGLE = 2'b01;
    localparam logic [1:0] C_INJ_DOUBLE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2
    } tx_state_t;

    // Double flips wrap from bit 7 back to bit 0 via 3-bit overflow.
    function automatic logic [7:0] inj_mask(input logic [1:0] mode,
                                            input logic [2:0] pos);
        logic [2:0] pos_next;
        logic [7:0] mask;
        pos_next = pos + 3'd1;
        mask     = 8'h00;
        case (mode)
            C_INJ_SINGLE: mask = 8'd1 << pos;
            C_INJ_DOUBLE: mask = (8'd1 << pos) | (8'd1 << pos_next);
            default:      mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_nibble_enc.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_nibble_enc
//  Purpose  : Combinational SECDED encoder, one 4-bit nibble to an 8-bit
//             Hamming(7,4) codeword plus overall parity bit.
//  Ports    : i_nibble [3:0] - data nibble {d3,d2,d1,d0}
//             o_code   [7:0] - codeword {c_all,d3,d2,d1,c2,d0,c1,c0}
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_nibble_enc
    import hamming_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_code
);

    logic [7:0] w_code;

    always_comb begin
        w_code             = 8'h00;
        w_code[C_BIT_D0]   = i_nibble[0];
        w_code[C_BIT_D1]   = i_nibble[1];
        w_code[C_BIT_D2]   = i_nibble[2];
        w_code[C_BIT_D3]   = i_nibble[3];
        w_code[C_BIT_C0]   = i_nibble[0] ^ i_nibble[1] ^ i_nibble[3];
        w_code[C_BIT_C1]   = i_nibble[0] ^ i_nibble[2] ^ i_nibble[3];
        w_code[C_BIT_C2]   = i_nibble[1] ^ i_nibble[2] ^ i_nibble[3];
        // Overall parity covers the seven Hamming bits, giving double-error detection
        w_code[C_BIT_CALL] = ^w_code[6:0];
    end

    assign o_code = w_code;

endmodule
`default_nettype wire

// File: rtl/hamming_encoder_tx.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_encoder_tx
//  Purpose  : Byte-to-SECDED transmitter. Each accepted byte is sent as two
//             codewords (low nibble first) over a valid/ready link, with
//             optional single/double bit-flip injection for decoder testing.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             in_data/valid/ready   - byte input handshake
//             inj_mode, inj_pos     - fault injection controls (with the byte)
//             code_out/valid/ready  - codeword output handshake
//             code_last             - high-nibble codeword marker
//             byte_count            - completed bytes, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_encoder_tx
    import hamming_pkg::*;
#(
    parameter bit INJ_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] inj_mode,
    input  logic [2:0] inj_pos,
    output logic [7:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       code_last,
    output logic [7:0] byte_count
);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;

    // Only the high nibble is kept: the low codeword is built straight from in_data
    logic [3:0] r_hi_nib;
    logic [1:0] r_mode;
    logic [2:0] r_pos;

    logic [7:0] r_code;
    logic       r_valid;
    logic       r_last;
    logic [7:0] r_count;

    logic [7:0] w_code_nxt;
    logic       w_valid_nxt;
    logic       w_last_nxt;
    logic [7:0] w_count_nxt;
    logic       w_load;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_hs;
    logic [1:0] w_mode_in;
    logic [3:0] w_nibble;
    logic [7:0] w_mask;
    logic [7:0] w_enc;

    assign w_in_ready = ~rst & ((r_state == ST_IDLE) |
                                ((r_state == ST_SEND_HI) & code_ready));
    assign w_accept   = in_valid & w_in_ready;
    assign w_hs       = r_valid & code_ready;
    assign w_mode_in  = INJ_EN ? inj_mode : C_INJ_NONE;

    // A newly accepted byte always feeds the encoder; otherwise the stored
    // high nibble and its captured injection settings are used.
    assign w_nibble = w_accept ? in_data[3:0] : r_hi_nib;
    assign w_mask   = w_accept ? inj_mask(w_mode_in, inj_pos)
                               : inj_mask(r_mode, r_pos);

    hamming_nibble_enc u_enc (
        .i_nibble (w_nibble),
        .o_code   (w_enc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND_LO;
                    w_code_nxt  = w_enc ^ w_mask;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_load      = 1'b1;
                end
            end
            ST_SEND_LO: begin
                if (w_hs) begin
                    w_state_nxt = ST_SEND_HI;
                    w_code_nxt  = w_enc ^ w_mask;
                    w_last_nxt  = 1'b1;
                end
            end
            ST_SEND_HI: begin
                if (w_hs) begin
                    w_count_nxt = r_count + 8'd1;
                    if (w_accept) begin
                        w_state_nxt = ST_SEND_LO;
                        w_code_nxt  = w_enc ^ w_mask;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_code   <= 8'h00;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_count  <= 8'h00;
            r_hi_nib <= 4'h0;
            r_mode   <= 2'b00;
            r_pos    <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_count <= w_count_nxt;
            if (w_load) begin
                r_hi_nib <= in_data[7:4];
                r_mode   <= w_mode_in;
                r_pos    <= inj_pos;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign code_last  = r_last;
    assign byte_count = r_count;

endmodule
`default_nettype wire
